vga_sync: RTL and testbench

- Generates the 640x480 @ 60 Hz VGA raster timing for the game display.
- Produces the pixel coordinates x and y consumed by the sky background generator and the other sprite/background stages, plus the hsync/vsync signals for the monitor and the video_on blanking qualifier for the final pixel mux.
- Derives the pixel rate from the 100 MHz board clock through an internal clock-enable divider. No derived clocks.

---
 rtl/vga_sync.sv | 104 ++++++++++
 tb/tb_vga_sync.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync.sv
// vga_sync: 640x480@60Hz VGA raster timing generator with a clock-enable pixel divider.
// Ports:
//   clk         in   system clock (100 MHz)
//   reset       in   asynchronous active-high reset
//   hsync       out  horizontal sync, active low, registered
//   vsync       out  vertical sync, active low, registered
//   video_on    out  high while (x,y) lies in the visible area, registered
//   p_tick      out  pixel-rate enable, one clk wide every CLK_DIV clks
//   x           out  current pixel column, 0..H_TOTAL-1
//   y           out  current line, 0..V_TOTAL-1
//   frame_start out  one-clk pulse when (x,y) wraps to (0,0)
module vga_sync #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int TW      = $clog2(CLK_DIV);

    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
    localparam logic [9:0]    X_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]    Y_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]    X_VIS     = 10'(H_DISPLAY);
    localparam logic [9:0]    Y_VIS     = 10'(V_DISPLAY);
    localparam logic [9:0]    HS_FIRST  = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0]    HS_LAST   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0]    VS_FIRST  = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0]    VS_LAST   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("vga_sync: CLK_DIV must be >= 2");
    end
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_sync: raster totals must fit in 10 bits");
    end

    logic [TW-1:0] tick_q, tick_d;
    logic [9:0]    x_q, x_d, y_q, y_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          video_on_q, video_on_d;
    logic          frame_start_q, frame_start_d;
    logic          x_wrap, y_wrap;

    assign p_tick = (tick_q == TICK_LAST);
    assign x_wrap = p_tick && (x_q == X_LAST);
    assign y_wrap = x_wrap && (y_q == Y_LAST);

    // Decodes use the next counter values so the registered outputs line up
    // with the x/y that appear on the same edge.
    always_comb begin
        tick_d        = p_tick ? '0 : tick_q + 1'b1;
        x_d           = p_tick ? (x_wrap ? '0 : x_q + 10'd1) : x_q;
        y_d           = x_wrap ? ((y_q == Y_LAST) ? '0 : y_q + 10'd1) : y_q;
        hsync_d       = !(x_d >= HS_FIRST && x_d <= HS_LAST);
        vsync_d       = !(y_d >= VS_FIRST && y_d <= VS_LAST);
        video_on_d    = (x_d < X_VIS) && (y_d < Y_VIS);
        frame_start_d = y_wrap;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q        <= '0;
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            tick_q        <= tick_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: checks three vga_sync configurations against an arithmetic raster model.
module tb_vga_sync;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hs[3], vs[3], von[3], pt[3], fs[3];
    logic [9:0] xs[3], ys[3];
    int         n = 0;
    int         checks = 0;
    int         errors = 0;

    localparam int CD[3]  = '{4, 2, 3};
    localparam int HD[3]  = '{640, 640, 16};
    localparam int HF[3]  = '{16, 16, 2};
    localparam int HSW[3] = '{96, 96, 4};
    localparam int HB[3]  = '{48, 48, 3};
    localparam int VD[3]  = '{480, 480, 8};
    localparam int VF[3]  = '{10, 10, 2};
    localparam int VSW[3] = '{2, 2, 2};
    localparam int VB[3]  = '{33, 33, 3};

    always #5 clk = ~clk;

    // clk edges seen since reset release; the model derives everything from it
    always @(posedge clk or posedge reset) n <= reset ? 0 : n + 1;

    vga_sync u0 (.clk(clk), .reset(reset), .hsync(hs[0]), .vsync(vs[0]), .video_on(von[0]),
                 .p_tick(pt[0]), .x(xs[0]), .y(ys[0]), .frame_start(fs[0]));
    vga_sync #(.CLK_DIV(2)) u1 (.clk(clk), .reset(reset), .hsync(hs[1]), .vsync(vs[1]),
                 .video_on(von[1]), .p_tick(pt[1]), .x(xs[1]), .y(ys[1]), .frame_start(fs[1]));
    vga_sync #(.CLK_DIV(3), .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
               .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)) u2 (
                 .clk(clk), .reset(reset), .hsync(hs[2]), .vsync(vs[2]), .video_on(von[2]),
                 .p_tick(pt[2]), .x(xs[2]), .y(ys[2]), .frame_start(fs[2]));

    // Expected {hsync,vsync,video_on,p_tick,frame_start,x,y} after k clk edges
    function automatic logic [24:0] model(int i, int k);
        int ht, vt, pix, xm, ym;
        logic h, v, on, tk, f;
        ht  = HD[i] + HF[i] + HSW[i] + HB[i];
        vt  = VD[i] + VF[i] + VSW[i] + VB[i];
        pix = k / CD[i];
        xm  = pix % ht;
        ym  = (pix / ht) % vt;
        tk  = (k % CD[i]) == CD[i] - 1;
        h   = !(xm >= HD[i] + HF[i] && xm < HD[i] + HF[i] + HSW[i]);
        v   = !(ym >= VD[i] + VF[i] && ym < VD[i] + VF[i] + VSW[i]);
        on  = k > 0 && xm < HD[i] && ym < VD[i];
        f   = k > 0 && (k % CD[i]) == 0 && (pix % (ht * vt)) == 0;
        return {h, v, on, tk, f, 10'(xm), 10'(ym)};
    endfunction

    function automatic logic [24:0] obs(int i);
        return {hs[i], vs[i], von[i], pt[i], fs[i], xs[i], ys[i]};
    endfunction

    task automatic test_reset();
        logic [24:0] e;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            e = model(i, 0);
            checks++;
            if (obs(i) !== e) begin
                errors++;
                $display("FAIL reset_hold dut%0d got=%h exp=%h", i, obs(i), e);
            end
        end
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 3; i++) begin
                e = model(i, n);
                checks++;
                if (obs(i) !== e) begin
                    errors++;
                    $display("FAIL reset_release dut%0d n=%0d got=%h exp=%h", i, n, obs(i), e);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_line();
        logic [24:0] e;
        int hf0 = -1, hr0 = -1, hf1 = -1, hr1 = -1, vof0 = -1;
        logic ph0, ph1, pv0;
        ph0 = hs[0];
        ph1 = hs[1];
        pv0 = von[0];
        while (n < 3300) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                e = model(i, n);
                checks++;
                if (obs(i) !== e) begin
                    errors++;
                    $display("FAIL line dut%0d n=%0d got=%h exp=%h", i, n, obs(i), e);
                end
            end
            if (ph0 && !hs[0] && hf0 < 0) hf0 = n;
            if (!ph0 && hs[0] && hr0 < 0) hr0 = n;
            if (ph1 && !hs[1] && hf1 < 0) hf1 = n;
            if (!ph1 && hs[1] && hr1 < 0) hr1 = n;
            if (pv0 && !von[0] && vof0 < 0) vof0 = n;
            ph0 = hs[0];
            ph1 = hs[1];
            pv0 = von[0];
            if (n == 3200) begin
                checks++;
                if ({xs[0], ys[0]} !== {10'd0, 10'd1}) begin
                    errors++;
                    $display("FAIL line_wrap0 got x=%0d y=%0d exp x=0 y=1", xs[0], ys[0]);
                end
            end
            if (n == 1600) begin
                checks++;
                if ({xs[1], ys[1]} !== {10'd0, 10'd1}) begin
                    errors++;
                    $display("FAIL line_wrap1 got x=%0d y=%0d exp x=0 y=1", xs[1], ys[1]);
                end
            end
        end
        checks++;
        if (hf0 != 2624) begin errors++; $display("FAIL hsync_fall0 got=%0d exp=2624", hf0); end
        checks++;
        if (hr0 - hf0 != 384) begin errors++; $display("FAIL hsync_low0 got=%0d exp=384", hr0 - hf0); end
        checks++;
        if (hf1 != 1312) begin errors++; $display("FAIL hsync_fall1 got=%0d exp=1312", hf1); end
        checks++;
        if (hr1 - hf1 != 192) begin errors++; $display("FAIL hsync_low1 got=%0d exp=192", hr1 - hf1); end
        checks++;
        if (vof0 != 2560) begin errors++; $display("FAIL video_off0 got=%0d exp=2560", vof0); end
    endtask

    task automatic test_frame();
        logic [24:0] e;
        int last = -1, pulses = 0, vfall = -1, vrise = -1;
        logic pv;
        pv = vs[2];
        while (n < 6000) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                e = model(i, n);
                checks++;
                if (obs(i) !== e) begin
                    errors++;
                    $display("FAIL frame dut%0d n=%0d got=%h exp=%h", i, n, obs(i), e);
                end
            end
            if (fs[2]) begin
                checks++;
                if (xs[2] !== 10'd0 || ys[2] !== 10'd0) begin
                    errors++;
                    $display("FAIL frame_pos got x=%0d y=%0d exp x=0 y=0", xs[2], ys[2]);
                end
                if (last >= 0) begin
                    checks++;
                    if (n - last != 1125) begin
                        errors++;
                        $display("FAIL frame_period got=%0d exp=1125", n - last);
                    end
                end
                last = n;
                pulses++;
            end
            if (ys[2] >= 10'd8) begin
                checks++;
                if (von[2] !== 1'b0) begin
                    errors++;
                    $display("FAIL blank_rows n=%0d got=%b exp=0", n, von[2]);
                end
            end
            if (pv && !vs[2] && vfall < 0) vfall = n;
            if (!pv && vs[2] && vfall >= 0 && vrise < 0) vrise = n;
            pv = vs[2];
        end
        checks++;
        if (pulses != 3) begin errors++; $display("FAIL frame_pulses got=%0d exp=3", pulses); end
        checks++;
        if (vrise - vfall != 150) begin errors++; $display("FAIL vsync_low got=%0d exp=150", vrise - vfall); end
    endtask

    task automatic test_mid_reset();
        logic [24:0] e;
        for (int r = 0; r < 3; r++) begin
            int len  = $urandom_range(200, 2500);
            int hold = $urandom_range(1, 4);
            repeat (len) begin
                @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    e = model(i, n);
                    checks++;
                    if (obs(i) !== e) begin
                        errors++;
                        $display("FAIL run dut%0d n=%0d got=%h exp=%h", i, n, obs(i), e);
                    end
                end
            end
            @(posedge clk);
            #2 reset = 1'b1;
            #1;
            for (int i = 0; i < 3; i++) begin
                e = model(i, 0);
                checks++;
                if (obs(i) !== e) begin
                    errors++;
                    $display("FAIL async_reset dut%0d got=%h exp=%h", i, obs(i), e);
                end
            end
            repeat (hold) @(negedge clk);
            reset = 1'b0;
            for (int k = 0; k < 40; k++) begin
                for (int i = 0; i < 3; i++) begin
                    e = model(i, n);
                    checks++;
                    if (obs(i) !== e) begin
                        errors++;
                        $display("FAIL restart dut%0d n=%0d got=%h exp=%h", i, n, obs(i), e);
                    end
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
